// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite types, widths and response codes
package axi_lite_pkg;

    localparam int ADDR_WIDTH        = 12;
    localparam int DATA_WIDTH        = 32;
    localparam int STRB_WIDTH        = DATA_WIDTH / 8;
    localparam int MEM_WORDS_DEFAULT = 256;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    // Word index: address with the byte offset bits dropped.
    typedef logic [ADDR_WIDTH-3:0] word_idx_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// rtl/axi_lite_mem_array.sv - word memory, byte-enabled sync write, sync read-before-write
// Ports:
//   clk_i, rst_i      clock and sync active-high reset (clears the read register only)
//   we_i/waddr_i/wdata_i/wstrb_i   byte-enabled write port
//   re_i/raddr_i/rdata_o           registered read port; rdata_o holds until the next re_i
module axi_lite_mem_array
    import axi_lite_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [STRB_WIDTH-1:0]        wstrb_i,
    input  logic                         re_i,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    data_t mem_q [MEM_WORDS];
    data_t rdata_q;

    // Contents are never reset; only bytes with a set strobe are touched.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Non-blocking read of mem_q returns the value from before a same-edge write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_resp_mem.sv
// rtl/axi_lite_resp_mem.sv - AXI4-Lite responder backed by a byte-strobed word memory
// Ports:
//   aclk, areset              clock, sync active-high reset
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready       write response channel
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel
module axi_lite_resp_mem
    import axi_lite_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    function automatic logic idx_ok(word_idx_t idx);
        return int'(idx) < MEM_WORDS;
    endfunction

    rd_state_t rd_state_q;
    wr_state_t wr_state_q;
    resp_t     rresp_q;
    resp_t     bresp_q;
    word_idx_t aw_idx_q;
    data_t     wdata_q;
    strb_t     wstrb_q;

    word_idx_t aw_idx;
    word_idx_t ar_idx;
    logic      unused_addr_lsbs;

    assign aw_idx           = awaddr[ADDR_WIDTH-1:2];
    assign ar_idx           = araddr[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    // All channel signals are held inactive while reset is asserted so that
    // no handshake can complete during reset.
    assign arready = !areset && (rd_state_q == RD_IDLE);
    assign rvalid  = !areset && (rd_state_q == RD_RESP);
    assign awready = !areset && ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_DATA));
    assign wready  = !areset && ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_ADDR));
    assign bvalid  = !areset && (wr_state_q == WR_RESP);
    assign bresp   = bresp_q;
    assign rresp   = rresp_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid  && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bvalid  && bready;

    // Commit source: whichever half arrives on the completing edge comes
    // straight from the bus, the other half from its holding register.
    logic      wr_done;
    word_idx_t c_idx;
    data_t     c_data;
    strb_t     c_strb;
    logic      c_ok;

    always_comb begin
        wr_done = 1'b0;
        c_idx   = aw_idx_q;
        c_data  = wdata_q;
        c_strb  = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                wr_done = aw_hs && w_hs;
                c_idx   = aw_idx;
                c_data  = wdata;
                c_strb  = wstrb;
            end
            WR_HAVE_ADDR: begin
                wr_done = w_hs;
                c_data  = wdata;
                c_strb  = wstrb;
            end
            WR_HAVE_DATA: begin
                wr_done = aw_hs;
                c_idx   = aw_idx;
            end
            default: ;
        endcase
    end

    assign c_ok = idx_ok(c_idx);

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= RD_IDLE;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (ar_hs) begin
                    rd_state_q <= RD_RESP;
                    rresp_q    <= idx_ok(ar_idx) ? RESP_OKAY : RESP_DECERR;
                end
                RD_RESP: if (r_hs) rd_state_q <= RD_IDLE;
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            bresp_q    <= RESP_OKAY;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= aw_idx;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (wr_done) bresp_q <= c_ok ? RESP_OKAY : RESP_DECERR;
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs && w_hs) wr_state_q <= WR_RESP;
                    else if (aw_hs)    wr_state_q <= WR_HAVE_ADDR;
                    else if (w_hs)     wr_state_q <= WR_HAVE_DATA;
                end
                WR_HAVE_ADDR: if (w_hs)  wr_state_q <= WR_RESP;
                WR_HAVE_DATA: if (aw_hs) wr_state_q <= WR_RESP;
                WR_RESP:      if (b_hs)  wr_state_q <= WR_IDLE;
                default:      wr_state_q <= WR_IDLE;
            endcase
        end
    end

    data_t mem_rdata;

    axi_lite_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk_i   (aclk),
        .rst_i   (areset),
        .we_i    (wr_done && c_ok),
        .waddr_i (c_idx[IDX_W-1:0]),
        .wdata_i (c_data),
        .wstrb_i (c_strb),
        .re_i    (ar_hs && idx_ok(ar_idx)),
        .raddr_i (ar_idx[IDX_W-1:0]),
        .rdata_o (mem_rdata)
    );

    // The memory read register holds until the next read, so rdata is stable
    // for the whole response; a decode error forces zero data.
    assign rdata = (rresp_q == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: doc/axi_lite_resp_mem.md
# axi_lite_resp_mem

AXI4-Lite responder (slave end) backed by a byte-strobed word memory; the counterpart to the team's AXI4-Lite initiator and the target used by the interconnect bench. It accepts read and write transactions on independent channels and returns data and OKAY/DECERR responses. Write address and write data may arrive in either order or in the same cycle. It sits on one slave port of the interconnect and is checked by the existing monitor and scoreboard.

## Interface
- MEM_WORDS, 256: number of 32-bit words; word index = addr[ADDR_WIDTH-1:2].
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1; awready  out  1.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1; wready  out  1.
- bresp  out  2  write response.
- bvalid  out  1; bready  in  1.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1; arready  out  1.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1; rready  in  1.

## Operation
- Address decode: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Index < MEM_WORDS → RESP_OKAY; otherwise RESP_DECERR.
- Read FSM (rd_state_t): RD_IDLE → RD_RESP on arvalid&&arready; RD_RESP → RD_IDLE on rvalid&&rready.
  - arready = (state==RD_IDLE); rvalid = (state==RD_RESP).
  - rdata/rresp are registered at the AR handshake and held stable while rvalid=1.
  - On DECERR: rdata=0.
- Write FSM (wr_state_t): WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP.
  - awready is high in WR_IDLE and WR_HAVE_DATA. wready is high in WR_IDLE and WR_HAVE_ADDR.
  - The address is latched on AW handshake; data and strobe are latched on W handshake.
  - WR_IDLE transitions:
    - AW only → WR_HAVE_ADDR.
    - W only → WR_HAVE_DATA.
    - Both in the same cycle → WR_RESP.
  - WR_HAVE_ADDR → WR_RESP on W handshake. WR_HAVE_DATA → WR_RESP on AW handshake.
  - Memory commit happens at the clock edge that completes the second (or simultaneous) handshake. Only bytes with wstrb=1 are written.
  - wstrb=0 writes nothing and returns OKAY. A DECERR write leaves memory untouched.
  - WR_RESP: bvalid=1 and bresp held stable; → WR_IDLE on bready.
- Read and write paths are fully independent; no ordering between them.
- Same-address collision: if an AR handshake and a write commit occur on the same edge, the read returns the pre-write data.
- Memory is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. FSMs are in RD_IDLE/WR_IDLE from the first cycle after reset deasserts, so the readies are 1 there.
- Read latency: AR handshake in cycle N → rvalid=1 in N+1. With rready held high, arready returns in N+2, giving 1 read per 2 cycles.
- Write latency: last of AW/W handshakes in cycle N → bvalid=1 in N+1. With bready held high, awready/wready return in N+2.
- Backpressure: rvalid/bvalid stay asserted and their payload stays unchanged until the corresponding ready is seen.
- No new AR is accepted while rvalid=1. No new AW/W is accepted while bvalid=1.
- Reset mid-transaction: latched address/data and any pending response are discarded, with no response issued. A write already committed stays in memory.

## Structure
- Add to axi_lite_pkg:
  - rd_state_t {RD_IDLE, RD_RESP}.
  - wr_state_t {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP}.
  - Reuse the existing addr_t, data_t, strb_t, resp_t, RESP_OKAY and RESP_DECERR.
- One sub-module: axi_lite_mem_array, MEM_WORDS × DATA_WIDTH.
  - One byte-enabled synchronous write port.
  - One synchronous read port, read-before-write.
- Top module holds both FSMs, address decode and response registers.

## Test plan
- Write awaddr=0x010, wdata=0xDEADBEEF, wstrb=0xF (AW and W same cycle) → bvalid next cycle, bresp=OKAY. Then read 0x010 → rdata=0xDEADBEEF, rresp=OKAY, rvalid exactly 1 cycle after AR handshake.
- AW at 0x020 in cycle 0, W 0x11223344 strb=0xF in cycle 3 → awready=0, wready=1 during cycles 1-3; bvalid in cycle 4. Repeat with W before AW, same result.
- Partial strobe: 0x020 holds 0x11223344; write wdata=0xAABBCCDD, wstrb=0x5 → read returns 0x11BB33DD.
- Out of range: write and read at 0x400 (index 256) → bresp=DECERR, rresp=DECERR, rdata=0. Word 0 is unchanged.
- Backpressure: hold rready=0 for 5 cycles → rvalid and rdata stable, arready=0 throughout. Same with bready=0, with awready/wready=0 throughout.
- Assert areset in WR_HAVE_ADDR and in RD_RESP → the cycle after reset deasserts, all readies=1, rvalid=bvalid=0, and no response is issued for the aborted transactions.
